// File: rtl/frame_scheduler_pkg.sv
// Shared definitions for the frame scheduler: sequencing states and default grid width.
package frame_scheduler_pkg;

  localparam int GRID_BITS = 256;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_EVT  = 3'd1,
    ST_STEP      = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_LAUNCH    = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/frame_scheduler_tick_divider.sv
// Gravity divider: counts 0..TICK_DIV-1 while enabled and flags the terminal count.
module frame_scheduler_tick_divider #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  // Counter wraps at the terminal count and is held at zero while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (!i_enable) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tick = i_enable && (r_count == LAST);

endmodule

// File: rtl/frame_scheduler.sv
// Paces grid steps from gravity ticks and button requests, then snapshots the grid
// and hands it to the LED controller with a start/finished handshake.
module frame_scheduler #(
  parameter int TICK_DIV  = 25000000,
  parameter int TIMEOUT   = 1048576,
  parameter int GRID_BITS = frame_scheduler_pkg::GRID_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 led_finished,
  input  logic [GRID_BITS-1:0] grid_in,
  output logic                 grid_enable,
  output logic                 grid_ctrl1,
  output logic                 grid_ctrl2,
  output logic                 led_start,
  output logic [GRID_BITS-1:0] frame_out,
  output logic                 busy,
  output logic [15:0]          frame_count,
  output logic                 timeout_err
);
  import frame_scheduler_pkg::*;

  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_t r_state, w_next;

  logic          r_left_prev, r_right_prev;
  logic          r_left_pend, r_right_pend, r_tick_pend;
  logic [WW-1:0] r_wait_cnt;

  logic w_tick, w_tick_en, w_step, w_timeout;
  logic w_left_edge, w_right_edge;
  logic w_left_nxt, w_right_nxt, w_tick_nxt;

  logic                 r_grid_enable, r_grid_ctrl1, r_grid_ctrl2, r_led_start, r_busy;
  logic                 r_timeout_err;
  logic [GRID_BITS-1:0] r_frame;
  logic [15:0]          r_frame_count;

  assign w_tick_en = run && (r_state != ST_IDLE);

  frame_scheduler_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .clk      (clk),
    .reset    (reset),
    .i_enable (w_tick_en),
    .o_tick   (w_tick)
  );

  // Pending flags clear in STEP, but an event in the same cycle re-arms its flag.
  assign w_step       = (r_state == ST_STEP);
  assign w_left_edge  = btn_left  & ~r_left_prev;
  assign w_right_edge = btn_right & ~r_right_prev;
  assign w_left_nxt   = (r_left_pend  & ~w_step) | w_left_edge;
  assign w_right_nxt  = (r_right_pend & ~w_step) | w_right_edge;
  assign w_tick_nxt   = (r_tick_pend  & ~w_step) | w_tick;

  // Next-state selection and timeout detection.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) w_next = ST_WAIT_EVT;
        else     w_next = ST_IDLE;
      end
      ST_WAIT_EVT: begin
        if (!run)                                           w_next = ST_IDLE;
        else if (r_left_pend || r_right_pend || r_tick_pend) w_next = ST_STEP;
        else                                                w_next = ST_WAIT_EVT;
      end
      ST_STEP:   w_next = ST_SETTLE;
      ST_SETTLE: w_next = ST_LAUNCH;
      ST_LAUNCH: w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (led_finished) begin
          w_next = run ? ST_WAIT_EVT : ST_IDLE;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_timeout = 1'b1;
          w_next    = run ? ST_WAIT_EVT : ST_IDLE;
        end else begin
          w_next = ST_WAIT_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_left_prev   <= 1'b0;
      r_right_prev  <= 1'b0;
      r_left_pend   <= 1'b0;
      r_right_pend  <= 1'b0;
      r_tick_pend   <= 1'b0;
      r_wait_cnt    <= '0;
      r_grid_enable <= 1'b0;
      r_grid_ctrl1  <= 1'b0;
      r_grid_ctrl2  <= 1'b0;
      r_led_start   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame       <= '0;
      r_frame_count <= 16'd0;
    end else begin
      r_state       <= w_next;
      r_left_prev   <= btn_left;
      r_right_prev  <= btn_right;
      r_left_pend   <= w_left_nxt;
      r_right_pend  <= w_right_nxt;
      r_tick_pend   <= w_tick_nxt;
      r_wait_cnt    <= ((r_state == ST_WAIT_DONE) && (w_next == ST_WAIT_DONE))
                       ? r_wait_cnt + WW'(1) : '0;
      r_grid_enable <= (w_next == ST_STEP);
      // Qualifiers reflect the flags as they will stand during STEP.
      r_grid_ctrl1  <= (w_next == ST_STEP) && w_left_nxt  && !w_right_nxt;
      r_grid_ctrl2  <= (w_next == ST_STEP) && w_right_nxt && !w_left_nxt;
      r_led_start   <= (w_next == ST_LAUNCH);
      r_busy        <= (w_next != ST_IDLE);
      if (w_next == ST_LAUNCH) begin
        r_frame       <= grid_in;
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign grid_enable = r_grid_enable;
  assign grid_ctrl1  = r_grid_ctrl1;
  assign grid_ctrl2  = r_grid_ctrl2;
  assign led_start   = r_led_start;
  assign frame_out   = r_frame;
  assign busy        = r_busy;
  assign frame_count = r_frame_count;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench: behavioural frame-age model compared every cycle, plus directed pins.
module tb_frame_scheduler;
  localparam int TD = 8;
  localparam int TO = 16;
  localparam int GB = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1, run = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic          led_finished = 1'b0;
  logic [GB-1:0] grid_in = '0;
  logic          grid_enable, grid_ctrl1, grid_ctrl2, led_start, busy, timeout_err;
  logic [GB-1:0] frame_out;
  logic [15:0]   frame_count;

  int n_vec = 0, n_err = 0;
  bit chk_en = 1'b0;
  int fin_delay = 3;
  bit rand_fin = 1'b0, stray_en = 1'b0;
  int fin_cnt = 0;

  frame_scheduler #(.TICK_DIV(TD), .TIMEOUT(TO), .GRID_BITS(GB)) dut (
    .clk(clk), .reset(reset), .run(run), .btn_left(btn_left), .btn_right(btn_right),
    .led_finished(led_finished), .grid_in(grid_in), .grid_enable(grid_enable),
    .grid_ctrl1(grid_ctrl1), .grid_ctrl2(grid_ctrl2), .led_start(led_start),
    .frame_out(frame_out), .busy(busy), .frame_count(frame_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [GB-1:0] rand_grid();
    logic [GB-1:0] g;
    for (int i = 0; i < GB / 32; i++) g[i*32 +: 32] = $urandom;
    return g;
  endfunction

  task automatic chk(input string nm, input logic [GB-1:0] act, input logic [GB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Mock grid: a fresh random grid after every step command.
  always @(posedge clk) if (grid_enable === 1'b1) grid_in <= rand_grid();

  // LED controller mock: finish a fixed/random number of cycles after led_start (0 = never).
  always @(negedge clk) begin
    int d;
    led_finished = 1'b0;
    if (fin_cnt > 0) begin
      fin_cnt--;
      if (fin_cnt == 0) led_finished = 1'b1;
    end else if (stray_en && $urandom_range(0, 39) == 0) begin
      led_finished = 1'b1;
    end
    if (led_start === 1'b1) begin
      if (rand_fin) begin
        d = $urandom_range(0, 9);
        fin_cnt = (d < 7) ? d + 1 : 0;
      end else begin
        fin_cnt = fin_delay;
      end
    end
  end

  // Behavioural model: m_age is cycles since the step command (-1 = waiting for an event).
  bit          m_idle = 1'b1, m_l, m_r, m_t, m_lp, m_rp, m_terr;
  int          m_age = -1, m_wait = 0, m_div = 0;
  logic [GB-1:0] m_frame = '0;
  logic [15:0] m_cnt = 16'd0;

  always @(posedge clk) begin : model
    bit tk, le, re, stp, any, going, leave;
    if (reset) begin
      m_idle = 1'b1; m_age = -1; m_wait = 0; m_div = 0;
      m_l = 1'b0; m_r = 1'b0; m_t = 1'b0; m_lp = 1'b0; m_rp = 1'b0; m_terr = 1'b0;
      m_frame = '0; m_cnt = 16'd0;
    end else begin
      going = !m_idle && run;
      tk    = going && (m_div == TD - 1);
      m_div = going ? (m_div + 1) % TD : 0;
      le = btn_left && !m_lp;
      re = btn_right && !m_rp;
      m_lp = btn_left; m_rp = btn_right;
      stp = !m_idle && (m_age == 0);
      any = m_l || m_r || m_t;
      m_l = (m_l && !stp) || le;
      m_r = (m_r && !stp) || re;
      m_t = (m_t && !stp) || tk;
      leave = 1'b0;
      if (m_idle) begin
        if (run) begin m_idle = 1'b0; m_age = -1; end
      end else if (m_age < 0) begin
        if (!run) m_idle = 1'b1;
        else if (any) m_age = 0;
      end else if (m_age < 3) begin
        if (m_age == 1) begin m_frame = grid_in; m_cnt = m_cnt + 16'd1; end
        m_age++;
        m_wait = 0;
      end else begin
        if (led_finished) leave = 1'b1;
        else if (m_wait == TO - 1) begin m_terr = 1'b1; leave = 1'b1; end
        else m_wait++;
        if (leave) begin
          if (run) m_age = -1;
          else m_idle = 1'b1;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    bit e_ge;
    if (chk_en) begin
      e_ge = !m_idle && (m_age == 0);
      chk("grid_enable", GB'(grid_enable), GB'(e_ge));
      chk("grid_ctrl1", GB'(grid_ctrl1), GB'(e_ge && m_l && !m_r));
      chk("grid_ctrl2", GB'(grid_ctrl2), GB'(e_ge && m_r && !m_l));
      chk("led_start", GB'(led_start), GB'(!m_idle && (m_age == 2)));
      chk("busy", GB'(busy), GB'(!m_idle));
      chk("frame_count", GB'(frame_count), GB'(m_cnt));
      chk("timeout_err", GB'(timeout_err), GB'(m_terr));
      chk("frame_out", frame_out, m_frame);
    end
  end

  task automatic wait_ge(input int budget, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (grid_enable !== 1'b1 && cyc < budget);
    if (grid_enable !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL wait_grid_enable: none within %0d cycles", budget);
    end
  endtask

  task automatic wait_ls(input int budget);
    int cyc = 0;
    do begin @(negedge clk); cyc++; end while (led_start !== 1'b1 && cyc < budget);
    if (led_start !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL wait_led_start: none within %0d cycles", budget);
    end
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("pin_reset_busy", GB'(busy), '0);
    chk("pin_reset_count", GB'(frame_count), '0);
    chk("pin_reset_frame", frame_out, '0);

    // Plain gravity frames.
    reset = 1'b0;
    run   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_ge(40, cyc);
      chk("pin_step_gap", GB'(cyc), GB'((k == 1) ? 10 : 6));
      chk("pin_gravity_ctrl", GB'({grid_ctrl1, grid_ctrl2}), '0);
      @(negedge clk);
      @(negedge clk);
      chk("pin_led_start_lat", GB'(led_start), GB'(1));
      chk("pin_frame_snap", frame_out, grid_in);
      chk("pin_frame_count", GB'(frame_count), GB'(k));
    end

    // Left press during WAIT_DONE.
    @(negedge clk);
    btn_left = 1'b1;
    wait_ge(40, cyc);
    chk("pin_left_ctrl", GB'({grid_ctrl1, grid_ctrl2}), GB'(2));
    btn_left = 1'b0;
    wait_ge(40, cyc);
    chk("pin_after_left_ctrl", GB'({grid_ctrl1, grid_ctrl2}), '0);

    // Both buttons in the same cycle.
    wait_ls(40);
    @(negedge clk);
    btn_left  = 1'b1;
    btn_right = 1'b1;
    wait_ge(40, cyc);
    chk("pin_both_ctrl", GB'({grid_ctrl1, grid_ctrl2}), '0);
    btn_left  = 1'b0;
    btn_right = 1'b0;

    // No led_finished: timeout after 16 WAIT_DONE cycles.
    fin_delay = 0;
    wait_ls(40);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (timeout_err !== 1'b1 && cyc < 40);
    chk("pin_timeout_lat", GB'(cyc), GB'(17));
    fin_delay = 3;
    wait_ls(60);
    wait_ls(60);
    chk("pin_timeout_sticky", GB'(timeout_err), GB'(1));

    // Reset in the middle of WAIT_DONE.
    fin_delay = 0;
    wait_ls(60);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("pin_mid_reset_busy", GB'(busy), '0);
    chk("pin_mid_reset_ls", GB'(led_start), '0);
    chk("pin_mid_reset_count", GB'(frame_count), '0);
    chk("pin_mid_reset_terr", GB'(timeout_err), '0);
    chk("pin_mid_reset_frame", frame_out, '0);
    reset = 1'b0;
    fin_delay = 3;

    // Randomized traffic against the model.
    rand_fin = 1'b1;
    stray_en = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 149) == 0) run = ~run;
      if ($urandom_range(0, 11) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 11) == 0) btn_right = ~btn_right;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
